// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_W_DEFAULT = 64;

  // Fill bit for the divide-by-zero quotient; replicated to W bits gives all ones.
  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the remainder/quotient pair left,
// trial-subtract the divisor at W+1 bits and restore on a borrow.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic [W-1:0] r_cur,
  input  logic [W-1:0] q_cur,
  input  logic [W-1:0] d_cur,
  output logic [W-1:0] r_next,
  output logic [W-1:0] q_next
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       qbit;

  always_comb begin
    shifted = {r_cur, q_cur[W-1]};
    diff    = shifted - {1'b0, d_cur};
    // A set MSB means the subtraction borrowed, so the divisor did not fit.
    qbit    = ~diff[W];
    r_next  = qbit ? diff[W-1:0] : shifted[W-1:0];
    q_next  = {q_cur[W-2:0], qbit};
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the iterative restoring divider: operand capture, W-step loop
// and valid/ready handshakes. Optional macro DIV_EARLY_EXIT_EN skips the loop when dividend < divisor.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int W  = DIV_W_DEFAULT,
  parameter int CW = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  state_t         state_reg;
  logic [W-1:0]   q_reg;
  logic [W-1:0]   r_reg;
  logic [W-1:0]   d_reg;
  logic [CW-1:0]  cnt_reg;
  logic           dbz_reg;
  logic           out_valid_reg;
  logic           in_ready_reg;
  logic           busy_reg;

  logic [W-1:0]   r_next;
  logic [W-1:0]   q_next;

  div_step #(.W(W)) u_step (
    .r_cur  (r_reg),
    .q_cur  (q_reg),
    .d_cur  (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      r_reg         <= '0;
      d_reg         <= '0;
      cnt_reg       <= '0;
      dbz_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            dbz_reg      <= 1'b0;
            d_reg        <= divisor;
            cnt_reg      <= CW'(W - 1);
            if (divisor == '0) begin
              state_reg     <= DONE;
              q_reg         <= {W{DBZ_Q_FILL}};
              r_reg         <= dividend;
              dbz_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (dividend < divisor) begin
              state_reg     <= DONE;
              q_reg         <= '0;
              r_reg         <= dividend;
              out_valid_reg <= 1'b1;
            end
`endif
            else begin
              state_reg <= ITER;
              q_reg     <= dividend;
              r_reg     <= '0;
            end
          end
        end
        ITER: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign busy        = busy_reg;
  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl at W=8; expected results are hand-computed.
module tb_div_seq_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int LAT_FULL = W + 1;
`ifdef DIV_EARLY_EXIT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge (the accept edge); returns 1 time unit after it.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as clock 1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int elat);
    int lat;
    start_op(a, b);
    wait_done(lat);
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b latency=%0d", a, b, quotient, remainder, div_by_zero, lat);
    check("latency", 32'(lat), 32'(elat));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edbz));
    check("busy_in_done", 32'(busy), 32'd1);
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_release", 32'(out_valid), 32'd0);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int  lat;
    logic saw_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT_FULL);
    run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT_FULL);
    run_op(8'd0, 8'd9, 8'd0, 8'd0, 1'b0, LAT_SMALL);
    run_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);
    // div_by_zero must clear on the following accept
    run_op(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, LAT_SMALL);
    run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT_FULL);

    // Hold out_ready low in DONE; a new request meanwhile must be ignored.
    start_op(8'd37, 8'd5);
    wait_done(lat);
    check("hold_latency", 32'(lat), 32'(LAT_FULL));
    dividend = 8'd1;
    divisor  = 8'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_quotient", 32'(quotient), 32'd7);
      check("hold_remainder", 32'(remainder), 32'd2);
    end
    in_valid = 1'b0;
    $display("op 37/5 held 5 clocks -> q=%0d r=%0d", quotient, remainder);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    start_op(8'd50, 8'd6);
    check("next_accept_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("next_latency", 32'(lat), 32'(LAT_FULL));
    check("next_quotient", 32'(quotient), 32'd8);
    check("next_remainder", 32'(remainder), 32'd2);
    $display("op 50/6 -> q=%0d r=%0d latency=%0d", quotient, remainder, lat);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Abort 200/3 with rst on the 4th clock after accept.
    start_op(8'd200, 8'd3);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      saw_valid = saw_valid | out_valid;
    end
    check("abort_no_result", 32'(saw_valid), 32'd0);
    $display("op 200/3 aborted by rst");
    run_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, LAT_FULL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
